// File: rtl/bp_inject_arb.sv
// bp_inject_arb: round-robin arbiter that shares one BFT client injection port among K requesters.
// Define BP_INJECT_ARB_STATS_EN to add per-requester forwarded-beat counters on stat_grants.
module bp_inject_arb #(
   parameter int N    = 2,
   parameter int D_W  = 32,
   parameter int A_W  = $clog2(N) + 1,
   parameter int K    = 4,
   parameter int posx = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce,
   input  logic [K*(A_W+D_W+1)-1:0]   req_d,
   input  logic [K-1:0]               req_v,
   output logic [K-1:0]               req_bp,
   output logic [A_W+D_W:0]           c_o,
   output logic                       c_o_v,
   input  logic                       c_o_bp,
   output logic [$clog2(K)-1:0]       grant_id,
   output logic                       self_drop
`ifdef BP_INJECT_ARB_STATS_EN
   ,
   output logic [K*16-1:0]            stat_grants
`endif
);

   localparam int BW = A_W + D_W + 1;
   localparam int GW = $clog2(K);

   // Handshakes: a beat moves on a posedge where its valid is 1 and its backpressure is 0,
   // on both the requester side (req_v/req_bp) and the router side (c_o_v/c_o_bp).

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [GW-1:0] rr_q;
   logic [GW-1:0] win_idx;
   logic          win_found;
   logic [GW-1:0] rr_next;
   logic [BW-1:0] win_beat;
   logic          win_self;
   logic          slot_free;
   logic          grant;

   // Returns {found, index} of the first set bit scanning upward from ptr, modulo K.
   function automatic logic [GW:0] rr_pick(input logic [K-1:0] v, input logic [GW-1:0] ptr);
      logic [GW:0] res;
      int          idx;
      res = '0;
      for (int j = K - 1; j >= 0; j--) begin
         idx = int'(ptr) + j;
         if (idx >= K) idx = idx - K;
         if (v[idx[GW-1:0]]) res = {1'b1, idx[GW-1:0]};
      end
      return res;
   endfunction

   assign {win_found, win_idx} = rr_pick(req_v, rr_q);

   assign slot_free = (state_q == EMPTY) || !c_o_bp;
   assign grant     = ce && slot_free && win_found;
   assign win_beat  = req_d[int'(win_idx)*BW +: BW];
   assign win_self  = (win_beat[A_W+D_W-1:D_W] == A_W'(posx));
   assign rr_next   = (win_idx == GW'(K - 1)) ? '0 : win_idx + 1'b1;

   always_comb begin
      req_bp = '1;
      if (grant) req_bp[win_idx] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (grant && !win_self) state_d = FULL;
         end
         FULL: begin
            // A self-addressed winner is consumed but leaves the slot empty.
            if (grant)        state_d = win_self ? EMPTY : FULL;
            else if (!c_o_bp) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= EMPTY;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_o       <= '0;
         grant_id  <= '0;
         rr_q      <= '0;
         self_drop <= 1'b0;
      end else begin
         self_drop <= grant && win_self;
         if (grant) begin
            c_o      <= win_beat;
            grant_id <= win_idx;
            rr_q     <= rr_next;
         end
      end
   end

   assign c_o_v = (state_q == FULL);

`ifdef BP_INJECT_ARB_STATS_EN
   logic [15:0] stat_q [K];

   // Only beats accepted by the router count; self-dropped beats never reach c_o_v.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < K; i++) stat_q[i] <= '0;
      end else if (c_o_v && !c_o_bp && (stat_q[grant_id] != 16'hFFFF)) begin
         stat_q[grant_id] <= stat_q[grant_id] + 16'd1;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < K; i++) stat_grants[i*16 +: 16] = stat_q[i];
   end
`else
   // Counters are not built in this configuration.
`endif

endmodule
